// File: rtl/uart_rx_fsm.sv
// Purpose : UART receive control. Detects the start bit, runs the per-bit oversampling
//           edge counter that drives data_sampling, deserializes the frame LSB first,
//           and checks start, parity and stop before presenting the received byte.
// Latency : data_valid rises (1 + DWIDTH + par_en + 1) * prescale + 1 cycles after the
//           cycle in which IDLE sampled rx_in = 0.
// Backpressure: none. The serial line cannot be stalled, so every result is a
//           one-cycle pulse and p_data holds the last good byte until the next one.
//
// Ports:
//   clk              oversampling clock
//   rst              asynchronous, active-low reset
//   rx_in            synchronized serial line, idle high
//   prescale         oversampling ratio (8, 16 or 32), held static while busy
//   par_en, par_typ  parity present / parity type (0 even, 1 odd), latched at start detect
//   sampled_bit      majority-voted bit from data_sampling, valid in the bit-end cycle
//   data_sampling_en enables data_sampling, equal to busy
//   edge_counter     oversampling edge index within the current bit
//   p_data           last good received byte
//   data_valid       one-cycle pulse, p_data updated
//   par_err          one-cycle pulse, parity mismatch
//   stp_err          one-cycle pulse, stop bit sampled 0
//   strt_glitch      one-cycle pulse, start bit sampled 1
//   busy             high in every state except IDLE

module uart_rx_fsm #(
    parameter int PWIDTH = 6,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [PWIDTH-1:0] prescale,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              sampled_bit,
    output logic              data_sampling_en,
    output logic [PWIDTH-1:0] edge_counter,
    output logic [DWIDTH-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              strt_glitch,
    output logic              busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int                BW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [BW-1:0]     LAST_BIT = BW'(DWIDTH - 1);
    localparam logic [BW-1:0]     BIT_ONE  = BW'(1);
    localparam logic [PWIDTH-1:0] EDGE_ONE = PWIDTH'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [PWIDTH-1:0] r_edge_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic [DWIDTH-1:0] r_shift;
    logic [DWIDTH-1:0] r_p_data;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_frame_err;
    logic              r_data_valid;
    logic              r_par_err;
    logic              r_stp_err;
    logic              r_strt_glitch;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [2:0] w_state_nxt;
    logic       w_busy;
    logic       w_bit_end;
    logic       w_last_data;
    logic       w_start_det;
    logic       w_par_exp;
    logic       w_par_bad;

    assign w_busy      = (r_state != IDLE);
    // The last oversampling edge of a bit is where every bit decision is taken;
    // data_sampling has settled its majority vote well before this edge.
    assign w_bit_end   = w_busy && (r_edge_cnt == (prescale - EDGE_ONE));
    assign w_last_data = (r_bit_cnt == LAST_BIT);
    assign w_start_det = (r_state == IDLE) && !rx_in;
    // Expected parity bit: even parity is the XOR of the data, odd is its inverse.
    assign w_par_exp   = (^r_shift) ^ r_par_typ;
    assign w_par_bad   = (sampled_bit != w_par_exp);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!rx_in) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    // A start bit that votes high was only noise on the line.
                    w_state_nxt = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end && w_last_data) begin
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame configuration, captured at start detect so a change on the
    // inputs mid-frame cannot alter how the current frame is parsed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_start_det) begin
            r_par_en  <= par_en;
            r_par_typ <= par_typ;
        end
    end

    // ------------------------------------------------------------------
    // Oversampling edge counter: held at 0 in IDLE, so the first busy
    // cycle after start detect is edge 0 of the start bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
        end else if (!w_busy || w_bit_end) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + EDGE_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Data bit counter, only meaningful in DATA.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
        end else if (r_state != DATA) begin
            r_bit_cnt <= '0;
        end else if (w_bit_end) begin
            r_bit_cnt <= w_last_data ? '0 : (r_bit_cnt + BIT_ONE);
        end
    end

    // ------------------------------------------------------------------
    // Deserializer: bits arrive LSB first, so shifting right with the new
    // bit entering at the MSB leaves the first bit in bit 0 after DWIDTH shifts.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if ((r_state == DATA) && w_bit_end) begin
            r_shift <= {sampled_bit, r_shift[DWIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Frame error flag: remembers a parity failure until the stop bit so
    // the byte is not published; cleared whenever the FSM heads to IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
        end else if ((r_state == PARITY) && w_bit_end && w_par_bad) begin
            r_frame_err <= 1'b1;
        end else if (w_state_nxt == IDLE) begin
            r_frame_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Result pulses and output byte. Every pulse defaults low so none can
    // ever be wider than one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;
            r_p_data      <= '0;
        end else begin
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;
            if (w_bit_end) begin
                case (r_state)
                    START: begin
                        r_strt_glitch <= sampled_bit;
                    end
                    PARITY: begin
                        r_par_err <= w_par_bad;
                    end
                    STOP: begin
                        if (!sampled_bit) begin
                            r_stp_err <= 1'b1;
                        end else if (!r_frame_err) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy             = w_busy;
    assign data_sampling_en = w_busy;
    assign edge_counter     = r_edge_cnt;
    assign p_data           = r_p_data;
    assign data_valid       = r_data_valid;
    assign par_err          = r_par_err;
    assign stp_err          = r_stp_err;
    assign strt_glitch      = r_strt_glitch;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: drives serial frames, models the neighbouring
// data_sampling majority voter, and compares result pulses and p_data
// against a frame-level model of expected outcomes and their cycle stamps.
module tb_uart_rx_fsm;

    localparam int PW = 6;
    localparam int DW = 8;

    localparam int EV_DV = 0;
    localparam int EV_PE = 1;
    localparam int EV_SE = 2;
    localparam int EV_SG = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          par_typ;
    logic          sampled_bit;
    logic          data_sampling_en;
    logic [PW-1:0] edge_counter;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          strt_glitch;
    logic          busy;

    uart_rx_fsm #(.PWIDTH(PW), .DWIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_in            (rx_in),
        .prescale         (prescale),
        .par_en           (par_en),
        .par_typ          (par_typ),
        .sampled_bit      (sampled_bit),
        .data_sampling_en (data_sampling_en),
        .edge_counter     (edge_counter),
        .p_data           (p_data),
        .data_valid       (data_valid),
        .par_err          (par_err),
        .stp_err          (stp_err),
        .strt_glitch      (strt_glitch),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for data_sampling: three samples around mid-bit, majority vote.
    logic s0, s1, s2;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else if (data_sampling_en) begin
            if (int'(edge_counter) == int'(prescale) / 2 - 1) s0 <= rx_in;
            if (int'(edge_counter) == int'(prescale) / 2)     s1 <= rx_in;
            if (int'(edge_counter) == int'(prescale) / 2 + 1) s2 <= rx_in;
        end
    end
    assign sampled_bit = (s0 & s1) | (s0 & s2) | (s1 & s2);

    typedef struct {
        int kind;
        int t;
    } ev_t;

    ev_t        q_ev[$];
    int         total = 0;
    int         bad = 0;
    int         ncnt = 0;
    int         next_idle = 0;
    int         wide = 0;
    logic [7:0] model_pdata = 8'h00;
    logic       prev_dv = 1'b0, prev_pe = 1'b0, prev_se = 1'b0, prev_sg = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic log_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.t    = ncnt;
        q_ev.push_back(e);
    endtask

    // One cycle: advance to the falling edge, then record any result pulse.
    task automatic tick();
        @(negedge clk);
        ncnt++;
        if (data_valid)  log_ev(EV_DV);
        if (par_err)     log_ev(EV_PE);
        if (stp_err)     log_ev(EV_SE);
        if (strt_glitch) log_ev(EV_SG);
        if ((data_valid && prev_dv) || (par_err && prev_pe) ||
            (stp_err && prev_se) || (strt_glitch && prev_sg)) wide++;
        prev_dv = data_valid;
        prev_pe = par_err;
        prev_se = stp_err;
        prev_sg = strt_glitch;
    endtask

    task automatic chk_ev(input string tag, input int kind, input int exp_n, input int exp_t);
        int n  = 0;
        int tt = -1;
        foreach (q_ev[i]) begin
            if (q_ev[i].kind == kind) begin
                n++;
                tt = q_ev[i].t;
            end
        end
        chk({tag, " count"}, n, exp_n);
        if (exp_n > 0) chk({tag, " cycle"}, tt, exp_t);
    endtask

    task automatic wait_idle(input int gap);
        rx_in = 1'b1;
        while (ncnt < next_idle) tick();
        repeat (gap) tick();
    endtask

    // Sends one frame and checks its outcome. Detect cycle k is the cycle the
    // start bit is first on the line; results are stamped relative to it.
    task automatic send_frame(input int p, input logic [7:0] b, input logic pe,
                              input logic pt, input logic par_wrong,
                              input logic stop_bit, input int gap);
        int   k, len;
        logic par_exp, pbad;
        wait_idle(gap);
        prescale = PW'(p);
        par_en   = pe;
        par_typ  = pt;
        k        = ncnt;
        rx_in    = 1'b0;
        repeat (p) tick();
        for (int i = 0; i < DW; i++) begin
            rx_in = b[i];
            repeat (p) tick();
        end
        par_exp = (^b) ^ pt;
        if (pe) begin
            rx_in = par_wrong ? ~par_exp : par_exp;
            repeat (p) tick();
        end
        rx_in = stop_bit;
        repeat (p) tick();
        rx_in = 1'b1;
        len = (2 + DW + (pe ? 1 : 0)) * p + 1;
        tick();
        next_idle = k + len;
        pbad = pe && par_wrong;
        chk_ev("par_err", EV_PE, pbad ? 1 : 0, k + (2 + DW) * p + 1);
        chk_ev("stp_err", EV_SE, stop_bit ? 0 : 1, k + len);
        chk_ev("data_valid", EV_DV, (stop_bit && !pbad) ? 1 : 0, k + len);
        chk_ev("strt_glitch", EV_SG, 0, 0);
        if (stop_bit && !pbad) model_pdata = b;
        chk("p_data", p_data, model_pdata);
        chk("busy after frame", busy, 0);
        q_ev.delete();
    endtask

    task automatic send_glitch(input int p, input int low_len, input int gap);
        int k;
        wait_idle(gap);
        prescale = PW'(p);
        k        = ncnt;
        rx_in    = 1'b0;
        repeat (low_len) tick();
        rx_in = 1'b1;
        repeat (p + 1 - low_len) tick();
        next_idle = k + p + 1;
        chk_ev("glitch strt_glitch", EV_SG, 1, k + p + 1);
        chk_ev("glitch data_valid", EV_DV, 0, 0);
        chk_ev("glitch par_err", EV_PE, 0, 0);
        chk_ev("glitch stp_err", EV_SE, 0, 0);
        chk("glitch busy", busy, 0);
        chk("glitch p_data", p_data, model_pdata);
        q_ev.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " ds_en"}, data_sampling_en, 0);
        chk({tag, " edge_counter"}, edge_counter, 0);
        chk({tag, " p_data"}, p_data, 0);
        chk({tag, " data_valid"}, data_valid, 0);
        chk({tag, " par_err"}, par_err, 0);
        chk({tag, " stp_err"}, stp_err, 0);
        chk({tag, " strt_glitch"}, strt_glitch, 0);
    endtask

    initial begin
        int         p, sel;
        logic [7:0] b;
        rst      = 1'b0;
        rx_in    = 1'b1;
        prescale = PW'(8);
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();
        next_idle = ncnt;

        // Directed frames.
        send_frame(8,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        send_frame(16, 8'h3D, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        send_frame(32, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 3);
        send_frame(8,  8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        send_glitch(16, 3, 3);

        // Reset in the middle of the 4th data bit.
        wait_idle(2);
        prescale = PW'(16);
        par_en   = 1'b0;
        rx_in    = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 3; i++) begin
            rx_in = i[0];
            repeat (16) tick();
        end
        rx_in = 1'b1;
        repeat (8) tick();
        chk("busy before reset", busy, 1);
        rst = 1'b0;
        #1;
        chk_all_zero("mid-frame reset");
        repeat (3) tick();
        chk("events across reset", q_ev.size(), 0);
        q_ev.delete();
        rst         = 1'b1;
        model_pdata = 8'h00;
        next_idle   = ncnt + 1;
        send_frame(16, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 2));
            case (sel)
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) begin
                send_glitch(p, int'($urandom_range(1, p / 2 - 1)), int'($urandom_range(0, 3)));
            end else begin
                send_frame(p, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) != 0),
                           int'($urandom_range(0, 3)));
            end
        end

        chk("pulse width", wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
